// File: rtl/simon_pkg.sv
// Shared Simon Says types: LED colours, playback FSM states and the colour-to-LED decode.
package simon_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } colour_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } ledseq_state_t;

  function automatic logic [3:0] onehot4(input colour_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Signal bundle between the game FSM (master) and the LED sequence controller (slave).
interface led_seq_ctrl_if #(
  parameter int MAX_LEN = 16
) ();
  localparam int LW = $clog2(MAX_LEN) + 1;

  // No valid/ready pairs: clear, append and start are single-cycle command pulses that are
  // acted on in the cycle they are sampled or dropped; done is a one-cycle completion pulse.
  logic                 tick;
  logic                 clear;
  logic                 append;
  simon_pkg::colour_t   append_color;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 full;
  logic [LW-1:0]        seq_len;
  logic [3:0]           led;

  modport master (
    output tick, clear, append, append_color, start,
    input  busy, done, full, seq_len, led
  );

  modport slave (
    input  tick, clear, append, append_color, start,
    output busy, done, full, seq_len, led
  );

endinterface

// File: rtl/led_seq_ctrl_seq_mem.sv
// Colour sequence store: append-only write port, asynchronous read port and a saturating length.
module seq_mem
  import simon_pkg::*;
#(
  parameter int MAX_LEN = 16
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         clear_i,
  input  logic                         wr_en_i,
  input  colour_t                      wr_data_i,
  input  logic [$clog2(MAX_LEN)-1:0]   rd_idx_i,
  output colour_t                      rd_data_o,
  output logic [$clog2(MAX_LEN):0]     len_o,
  output logic                         full_o
);
  localparam int IW = $clog2(MAX_LEN);
  localparam int LW = IW + 1;

  colour_t       mem_q [MAX_LEN];
  logic [LW-1:0] len_q;
  logic [LW-1:0] len_d;
  logic          full;
  logic          do_wr;

  assign full  = (len_q == LW'(MAX_LEN));
  assign do_wr = wr_en_i && !full && !clear_i;

  always_comb begin
    len_d = len_q;
    if (clear_i) begin
      len_d = '0;
    end else if (do_wr) begin
      len_d = len_q + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      len_q <= '0;
    end else begin
      len_q <= len_d;
    end
  end

  // Only the low IW bits address the store; the write is blocked once len reaches MAX_LEN.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_q[i] <= RED;
      end
    end else if (do_wr) begin
      mem_q[len_q[IW-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign len_o     = len_q;
  assign full_o    = full;

endmodule

// File: rtl/led_seq_ctrl.sv
// Simon Says LED playback controller: steps through the stored sequence, lighting each colour
// for ON_TICKS tick strobes followed by an OFF_TICKS blank gap.
module led_seq_ctrl
  import simon_pkg::*;
#(
  parameter int MAX_LEN   = 16,
  parameter int ON_TICKS  = 4,
  parameter int OFF_TICKS = 2
) (
  input  logic           clk,
  input  logic           n_rst,
  led_seq_ctrl_if.slave  bus,
  output ledseq_state_t  state_o
);
  localparam int IW   = $clog2(MAX_LEN);
  localparam int LW   = IW + 1;
  localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  ledseq_state_t state_q;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] tcnt_q;
  logic          done_q;

  colour_t       rd_color;
  logic [LW-1:0] seq_len;
  logic          full;
  logic          wr_en;
  logic          last_step;
  logic          on_end;
  logic          gap_end;

  // Appends are only honoured in IDLE and lose to a same-cycle start or clear.
  assign wr_en = bus.append && !bus.start && !bus.clear && (state_q == IDLE);

  seq_mem #(
    .MAX_LEN (MAX_LEN)
  ) u_seq_mem (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear_i   (bus.clear),
    .wr_en_i   (wr_en),
    .wr_data_i (bus.append_color),
    .rd_idx_i  (idx_q),
    .rd_data_o (rd_color),
    .len_o     (seq_len),
    .full_o    (full)
  );

  assign last_step = ({1'b0, idx_q} == (seq_len - LW'(1)));
  assign on_end    = (tcnt_q == TW'(ON_TICKS - 1));
  assign gap_end   = (tcnt_q == TW'(OFF_TICKS - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.clear) begin
        state_q <= IDLE;
        idx_q   <= '0;
        tcnt_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              idx_q  <= '0;
              tcnt_q <= '0;
              if (seq_len != '0) begin
                state_q <= ON;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          ON: begin
            if (bus.tick) begin
              if (on_end) begin
                state_q <= GAP;
                tcnt_q  <= '0;
              end else begin
                tcnt_q <= tcnt_q + TW'(1);
              end
            end
          end
          GAP: begin
            if (bus.tick) begin
              if (gap_end) begin
                tcnt_q <= '0;
                if (last_step) begin
                  state_q <= IDLE;
                  idx_q   <= '0;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= ON;
                  idx_q   <= idx_q + IW'(1);
                end
              end else begin
                tcnt_q <= tcnt_q + TW'(1);
              end
            end
          end
          default: begin
            state_q <= IDLE;
            idx_q   <= '0;
            tcnt_q  <= '0;
          end
        endcase
      end
    end
  end

  // LED and busy are pure decodes of registered state, so reset blanks them immediately.
  assign bus.led     = (state_q == ON) ? onehot4(rd_color) : 4'b0000;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.full    = full;
  assign bus.seq_len = seq_len;
  assign state_o     = state_q;

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Playback controller for the Simon Says LED display. Stores the growing colour sequence (up to MAX_LEN entries) and, on request, plays it back on the four one-hot LED outputs. Each step is lit for ON_TICKS and blanked for OFF_TICKS pulses of the slow tick strobe produced by the LED clock divider. It sits between the game FSM, which appends colours and starts playback, and the LED pins.

## Interface
- MAX_LEN, 16: sequence capacity in entries; power of two, at least 2.
- ON_TICKS, 4: tick strobes each step is lit; at least 1.
- OFF_TICKS, 2: tick strobes of blank gap after each step; at least 1.

Ports:
- clk  in  1  system clock; all state on posedge.
- n_rst  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle timing strobe from the LED divider.
- clear  in  1  pulse: empty the sequence and abort any playback.
- append  in  1  pulse: push append_color onto the end of the sequence.
- append_color  in  2  colour_t (0 RED, 1 GREEN, 2 BLUE, 3 YELLOW).
- start  in  1  pulse: begin playback from entry 0.
- busy  out  1  high during playback.
- done  out  1  one-cycle pulse when playback completes.
- full  out  1  length == MAX_LEN.
- seq_len  out  $clog2(MAX_LEN)+1  current sequence length.
- led  out  4  one-hot lit colour; led[c] = 1 for colour c, or 4'b0000.

## Operation
- States: IDLE, ON, GAP.
- IDLE: led = 0, busy = 0.
- start with seq_len > 0 → ON with idx = 0 and tcnt = 0.
- start with seq_len == 0 → stay in IDLE and pulse done on the next cycle.
- ON: led = onehot(mem[idx]). Each tick increments tcnt. A tick with tcnt == ON_TICKS-1 → GAP with tcnt = 0.
- GAP: led = 0. A tick with tcnt == OFF_TICKS-1:
  - if idx == seq_len-1 → IDLE and pulse done;
  - otherwise idx+1 → ON with tcnt = 0.
- append, IDLE only, when not full: mem[seq_len] = append_color and seq_len+1.
  - Ignored when full.
  - Ignored while busy.
  - Ignored in the same cycle as start or clear.
- clear in any state:
  - seq_len = 0 and go to IDLE; led = 0 next cycle.
  - No done pulse. Memory contents are don't-care.
  - clear beats start and append in the same cycle.
- start while busy is ignored; playback is not restarted.
- seq_len saturates at MAX_LEN. idx and tcnt never wrap past their limits.

## Timing
- Reset values: state IDLE, seq_len 0, idx 0, tcnt 0, busy 0, done 0, full 0, led 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from an input to an output.
- start sampled at edge k → busy = 1 and led = first colour from cycle k+1.
- A tick in the same cycle as start is not counted.
- Step lit duration is exactly ON_TICKS tick strobes, counting ticks sampled while in ON. The gap is OFF_TICKS strobes.
- done is high for exactly the one cycle after the final GAP tick. busy falls in that same cycle.
- Appended entry is visible in seq_len and full the cycle after append.
- Reset asserted mid-playback clears everything immediately and asynchronously. The sequence is lost.

## Structure
- Shared package simon_pkg:
  - colour_t (2-bit enum);
  - ledseq_state_t (IDLE, ON, GAP);
  - function onehot4(colour_t) returning logic [3:0].
- The sequence store is a natural sub-module, seq_mem:
  - MAX_LEN × 2 flops;
  - write port (append) and asynchronous read port (idx);
  - length counter with full flag and clear.
- led_seq_ctrl holds the FSM, idx and tcnt.

## Test plan
- Reset, then append RED, BLUE, GREEN and start, with tick every 11 clocks → led = 0001 for 4 ticks, 0000 for 2, 0100 for 4, 0000 for 2, 0010 for 4, 0000 for 2. Then a single done pulse and busy = 0.
- start with empty sequence → no LED activity, busy stays 0, done pulses once one cycle later.
- Append 16 times with colour index mod 4 → full = 1 and seq_len = 16. A 17th append leaves seq_len = 16 and mem[15] unchanged.
- Mid-playback (during step 2 ON), assert clear → led = 0 and busy = 0 next cycle, no done, seq_len = 0. A subsequent start gives an immediate done.
- During playback, pulse start and append YELLOW → playback unaffected, seq_len unchanged. Same-cycle clear + append in IDLE → seq_len = 0.
- Drop n_rst during a GAP phase → all outputs 0 asynchronously. After release, IDLE with seq_len = 0.
